// File: rtl/divider_core_if.sv
// Handshake and operand/result bundle between the operand source,
// the divider core and the result consumer.
interface divider_core_if #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 7
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividendin;
    logic [DIVISOR_W-1:0]  divisorin;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    // Operand source / result consumer side
    modport master (
        output start, dividendin, divisorin,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side
    modport slave (
        input  start, dividendin, divisorin,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider_core.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// start/done handshake, registered results held until the next division.
module divider_core #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 7
) (
    input  logic          clk,
    input  logic          reset,
    divider_core_if.slave bus
);
    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE, ZERO} state_t;

    state_t                       state;
    logic        [DIVIDEND_W-1:0] q_sh;
    logic        [DIVISOR_W-1:0]  d_reg;
    // The partial remainder is always below the divisor, so its top bit
    // is always zero and only DIVISOR_W bits need to be held.
    logic        [DIVISOR_W-1:0]  p_rem;
    logic        [CNT_W-1:0]      cnt;

    logic        [DIVISOR_W:0]    trial;
    logic signed [DIVISOR_W+1:0]  diff;
    logic                         q_bit;
    logic        [DIVISOR_W-1:0]  p_next;

    logic                         busy_r;
    logic                         done_r;
    logic        [DIVIDEND_W-1:0] quot_r;
    logic        [DIVISOR_W-1:0]  rem_r;
    logic                         dz_r;

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quot_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dz_r;

    // Trial subtraction with a guard bit; a negative difference restores.
    always_comb begin
        trial  = {p_rem, q_sh[DIVIDEND_W-1]};
        diff   = $signed({1'b0, trial}) - $signed({2'b00, d_reg});
        q_bit  = (diff >= 0);
        p_next = q_bit ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
    end

    // Sequencing FSM, shift/subtract datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            q_sh   <= '0;
            d_reg  <= '0;
            p_rem  <= '0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            quot_r <= '0;
            rem_r  <= '0;
            dz_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_r <= 1'b1;
                        if (bus.divisorin != '0) begin
                            q_sh  <= bus.dividendin;
                            d_reg <= bus.divisorin;
                            p_rem <= '0;
                            cnt   <= CNT_W'(DIVIDEND_W);
                            state <= CALC;
                        end else begin
                            state <= ZERO;
                        end
                    end
                end
                CALC: begin
                    q_sh  <= {q_sh[DIVIDEND_W-2:0], q_bit};
                    p_rem <= p_next;
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    quot_r <= q_sh;
                    rem_r  <= p_rem;
                    dz_r   <= 1'b0;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                ZERO: begin
                    quot_r <= '1;
                    rem_r  <= '0;
                    dz_r   <= 1'b1;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_divider_core.sv
// Directed bench for divider_core: default 8/7 instance plus a 16/15 instance.
module tb_divider_core;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    divider_core_if #(.DIVIDEND_W(8),  .DIVISOR_W(7))  ifa ();
    divider_core_if #(.DIVIDEND_W(16), .DIVISOR_W(15)) ifb ();

    divider_core #(.DIVIDEND_W(8), .DIVISOR_W(7)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    divider_core #(.DIVIDEND_W(16), .DIVISOR_W(15)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic get_busy(input bit wide);
        return wide ? ifb.busy : ifa.busy;
    endfunction

    function automatic logic get_done(input bit wide);
        return wide ? ifb.done : ifa.done;
    endfunction

    function automatic logic [31:0] get_q(input bit wide);
        return wide ? {16'h0, ifb.quotient} : {24'h0, ifa.quotient};
    endfunction

    function automatic logic [31:0] get_r(input bit wide);
        return wide ? {17'h0, ifb.remainder} : {25'h0, ifa.remainder};
    endfunction

    function automatic logic get_z(input bit wide);
        return wide ? ifb.div_by_zero : ifa.div_by_zero;
    endfunction

    // One division: latency counted in edges after the accepting edge.
    // poke_at > 0 pulses a second start (50/5) on the narrow DUT mid-run.
    task automatic run_div(input string tag, input bit wide,
                           input logic [15:0] a, input logic [14:0] b,
                           input int exp_lat, input logic [31:0] eq,
                           input logic [31:0] er, input logic ez,
                           input int poke_at);
        int lat;
        int pulses;
        logic [31:0] held_q;
        held_q = get_q(wide);
        @(negedge clk);
        if (wide) begin
            ifb.dividendin = a;
            ifb.divisorin  = b;
            ifb.start      = 1'b1;
        end else begin
            ifa.dividendin = a[7:0];
            ifa.divisorin  = b[6:0];
            ifa.start      = 1'b1;
        end
        @(posedge clk);
        #1;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        check({tag, "_busy"}, {31'h0, get_busy(wide)}, 32'd1);
        lat    = -1;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (get_done(wide)) begin
                pulses++;
                if (lat < 0) lat = k;
            end
            if (k == 3 && lat < 0)
                check({tag, "_qhold"}, get_q(wide), held_q);
            if (poke_at > 0 && k == poke_at) begin
                ifa.dividendin = 8'd50;
                ifa.divisorin  = 7'd5;
                ifa.start      = 1'b1;
            end
            if (k == poke_at + 1) ifa.start = 1'b0;
            if (lat > 0 && k == lat) begin
                check({tag, "_q"},    get_q(wide), eq);
                check({tag, "_r"},    get_r(wide), er);
                check({tag, "_dz"},   {31'h0, get_z(wide)}, {31'h0, ez});
                check({tag, "_idle"}, {31'h0, get_busy(wide)}, 32'd0);
            end
            if (lat > 0 && k >= lat + 1) break;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_pulses"}, pulses, 32'd1);
    endtask

    initial begin
        int pulses;
        reset          = 1'b1;
        ifa.start      = 1'b0;
        ifa.dividendin = '0;
        ifa.divisorin  = '0;
        ifb.start      = 1'b0;
        ifb.dividendin = '0;
        ifb.divisorin  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, ifa.busy}, 32'd0);
        check("rst_done", {31'h0, ifa.done}, 32'd0);
        check("rst_q",    get_q(0), 32'd0);
        check("rst_r",    get_r(0), 32'd0);
        check("rst_dz",   {31'h0, ifa.div_by_zero}, 32'd0);
        check("rst_wq",   get_q(1), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_div("d200_7",   0, 16'd200, 15'd7,   9, 32'd28,  32'd4, 1'b0, 0);
        run_div("d255_1",   0, 16'd255, 15'd1,   9, 32'd255, 32'd0, 1'b0, 0);
        run_div("d5_100",   0, 16'd5,   15'd100, 9, 32'd0,   32'd5, 1'b0, 0);
        run_div("d255_127", 0, 16'd255, 15'd127, 9, 32'd2,   32'd1, 1'b0, 0);
        run_div("d42_0",    0, 16'd42,  15'd0,   1, 32'd255, 32'd0, 1'b1, 0);
        run_div("d10_3",    0, 16'd10,  15'd3,   9, 32'd3,   32'd1, 1'b0, 0);
        run_div("d100_9",   0, 16'd100, 15'd9,   9, 32'd11,  32'd1, 1'b0, 3);

        // Asynchronous reset in the middle of a division
        @(negedge clk);
        ifa.dividendin = 8'd200;
        ifa.divisorin  = 7'd7;
        ifa.start      = 1'b1;
        @(posedge clk);
        #1;
        ifa.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", {31'h0, ifa.busy}, 32'd0);
        check("arst_done", {31'h0, ifa.done}, 32'd0);
        check("arst_q",    get_q(0), 32'd0);
        check("arst_r",    get_r(0), 32'd0);
        check("arst_dz",   {31'h0, ifa.div_by_zero}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (ifa.done) pulses++;
        end
        check("arst_nodone", pulses, 32'd0);
        run_div("d13_4", 0, 16'd13, 15'd4, 9, 32'd3, 32'd1, 1'b0, 0);

        run_div("w65535_32767", 1, 16'd65535, 15'd32767, 17, 32'd2, 32'd1, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
